// File: rtl/wb_bus_bridge_if.sv
// wb_bus_bridge_if
//   Groups the memcontrol request side and the Wishbone classic-cycle side
//   of wb_bus_bridge into one bundle.
//   Request side : read_req, write_req, addr_in, wdata_in, sel_in  (to bridge)
//                  rdata_out, busy, done, err                      (from bridge)
//   Wishbone side: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
//                  wb_sel_o                                        (from bridge)
//                  wb_dat_i, wb_ack_i                              (to bridge)
//   modport master : the bridge's view (it is the Wishbone master)
//   modport slave  : the surrounding environment's view (requester + slave)
interface wb_bus_bridge_if;
   logic        read_req;
   logic        write_req;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic [3:0]  sel_in;
   logic [31:0] rdata_out;
   logic        busy;
   logic        done;
   logic        err;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   modport master (
      input  read_req, write_req, addr_in, wdata_in, sel_in, wb_dat_i, wb_ack_i,
      output rdata_out, busy, done, err,
             wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );

   modport slave (
      output read_req, write_req, addr_in, wdata_in, sel_in, wb_dat_i, wb_ack_i,
      input  rdata_out, busy, done, err,
             wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );
endinterface

// File: rtl/wb_bus_bridge.sv
// wb_bus_bridge
//   Turns memcontrol's single-word read/write requests into Wishbone
//   classic-cycle transactions, one outstanding at a time, with a timeout
//   against a slave that never acknowledges.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : wb_bus_bridge_if.master (request side + Wishbone master side)
//   All outputs are registered. busy is high only in BUS; done (and err on
//   timeout) pulse for the single DONE cycle that follows.
module wb_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   wb_bus_bridge_if.master bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             req;
   logic             ack_hit;
   logic             tmo_hit;

   assign req     = bus.read_req | bus.write_req;
   assign ack_hit = (state == BUS) && bus.wb_ack_i;
   // ack on the final allowed cycle wins over the timeout
   assign tmo_hit = (state == BUS) && !bus.wb_ack_i && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = req ? BUS : IDLE;
         BUS:     state_nxt = (ack_hit || tmo_hit) ? DONE : BUS;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         bus.rdata_out <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.wb_cyc_o  <= 1'b0;
         bus.wb_stb_o  <= 1'b0;
         bus.wb_we_o   <= 1'b0;
         bus.wb_adr_o  <= '0;
         bus.wb_dat_o  <= '0;
         bus.wb_sel_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
               if (req) begin
                  bus.wb_adr_o <= bus.addr_in;
                  bus.wb_dat_o <= bus.wdata_in;
                  // an all-zero byte enable means a full-word access
                  bus.wb_sel_o <= (bus.sel_in == '0) ? '1 : bus.sel_in;
                  // read wins when both requests are raised together
                  bus.wb_we_o  <= bus.write_req & ~bus.read_req;
                  bus.wb_cyc_o <= 1'b1;
                  bus.wb_stb_o <= 1'b1;
                  bus.busy     <= 1'b1;
                  cnt          <= '0;
               end
            end
            BUS: begin
               if (ack_hit) begin
                  bus.wb_cyc_o <= 1'b0;
                  bus.wb_stb_o <= 1'b0;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  if (!bus.wb_we_o) bus.rdata_out <= bus.wb_dat_i;
               end else if (tmo_hit) begin
                  bus.wb_cyc_o <= 1'b0;
                  bus.wb_stb_o <= 1'b0;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.err      <= 1'b1;
                  if (!bus.wb_we_o) bus.rdata_out <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
            end
            default: begin
               bus.wb_cyc_o <= 1'b0;
               bus.wb_stb_o <= 1'b0;
               bus.busy     <= 1'b0;
               bus.done     <= 1'b0;
               bus.err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_bus_bridge.sv
// tb_wb_bus_bridge
//   Randomized, scoreboarded bench for wb_bus_bridge. The stimulus process
//   pushes the expected outcome of each transaction; a Wishbone slave model
//   acknowledges after the per-transaction delay; a monitor checks bus
//   signals while cyc is high and pops/compares on every done pulse.
module tb_wb_bus_bridge;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_bus_bridge_if bus ();

   wb_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic        is_read;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          delay;      // BUS cycle index of the ack, <0 = never
      logic [31:0] sdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_busy;
   } txn_t;

   txn_t        sb[$];
   txn_t        mon_t;
   int          checks = 0;
   int          fails  = 0;
   logic [31:0] rd_model = '0;
   logic        stray_ack = 1'b0;
   int          slv_k = 0;
   int          busy_cnt = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Wishbone slave model
   always @(negedge clk) begin
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
         if (sb.size() > 0 && sb[0].delay >= 0 && slv_k == sb[0].delay) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = sb[0].sdata;
         end else begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = $urandom;
         end
         slv_k++;
      end else begin
         slv_k        = 0;
         bus.wb_ack_i = stray_ack;
         bus.wb_dat_i = stray_ack ? $urandom : 32'h0;
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.wb_cyc_o && sb.size() > 0) begin
            check("wb_adr_o", bus.wb_adr_o, sb[0].addr);
            check("wb_dat_o", bus.wb_dat_o, sb[0].wdata);
            check("wb_sel_o", {28'h0, bus.wb_sel_o}, {28'h0, sb[0].sel});
            check("wb_we_o", {31'h0, bus.wb_we_o}, {31'h0, ~sb[0].is_read});
            check("wb_stb_o", {31'h0, bus.wb_stb_o}, 32'h1);
            check("busy_in_bus", {31'h0, bus.busy}, 32'h1);
         end
         if (bus.err) check("err_with_done", {31'h0, bus.done}, 32'h1);
         if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_done: got done=1 required done=0 (t=%0t)", $time);
            end else begin
               mon_t = sb.pop_front();
               check("rdata_out", bus.rdata_out, mon_t.exp_rdata);
               check("err", {31'h0, bus.err}, {31'h0, mon_t.exp_err});
               check("busy_cycles", busy_cnt, mon_t.exp_busy);
               check("cyc_at_done", {31'h0, bus.wb_cyc_o}, 32'h0);
            end
            busy_cnt = 0;
         end
      end
   end

   function automatic void push_txn(input logic rd, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] s,
                                    input int delay, input logic [31:0] sdata);
      txn_t t;
      logic tmo;
      tmo         = (delay < 0) || (delay >= TMO);
      t.is_read   = rd;
      t.addr      = a;
      t.wdata     = d;
      t.sel       = (s == 4'h0) ? 4'hF : s;
      t.delay     = delay;
      t.sdata     = sdata;
      if (rd) rd_model = tmo ? 32'h0 : sdata;
      t.exp_rdata = rd_model;
      t.exp_err   = tmo;
      t.exp_busy  = tmo ? TMO : delay + 1;
      sb.push_back(t);
   endfunction

   // requester wanders on its inputs while busy; drops requests on done
   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < 40) begin
         bus.read_req  = 1'($urandom);
         bus.write_req = 1'($urandom);
         bus.addr_in   = $urandom;
         bus.wdata_in  = $urandom;
         bus.sel_in    = 4'($urandom);
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("done_timeout", 32'h0, 32'h1);
      bus.read_req  = 1'b0;
      bus.write_req = 1'b0;
      @(negedge clk);
      check("done_one_cycle", {31'h0, bus.done}, 32'h0);
      check("busy_after_done", {31'h0, bus.busy}, 32'h0);
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int delay, input logic [31:0] sdata);
      push_txn(rd, a, d, s, delay, sdata);
      bus.read_req  = rd;
      bus.write_req = wr;
      bus.addr_in   = a;
      bus.wdata_in  = d;
      bus.sel_in    = s;
      @(negedge clk);
      check("cyc_rise", {31'h0, bus.wb_cyc_o}, 32'h1);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       rd, wr;
      int         r, dly;
      logic [3:0] s;

      bus.read_req  = 1'b1;
      bus.write_req = 1'b0;
      bus.addr_in   = 32'h0000_0100;
      bus.wdata_in  = 32'hA5A5_A5A5;
      bus.sel_in    = 4'h0;

      // reset held with a pending read
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
      check("rst_stb", {31'h0, bus.wb_stb_o}, 32'h0);
      check("rst_busy", {31'h0, bus.busy}, 32'h0);
      check("rst_done", {31'h0, bus.done}, 32'h0);
      check("rst_err", {31'h0, bus.err}, 32'h0);
      check("rst_rdata", bus.rdata_out, 32'h0);
      check("rst_adr", bus.wb_adr_o, 32'h0);
      check("rst_dat", bus.wb_dat_o, 32'h0);
      check("rst_sel", {28'h0, bus.wb_sel_o}, 32'h0);
      check("rst_we", {31'h0, bus.wb_we_o}, 32'h0);
      push_txn(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'h0, 1, 32'h0BAD_F00D);
      rst = 1'b0;
      @(negedge clk);
      check("cyc_rise_after_rst", {31'h0, bus.wb_cyc_o}, 32'h1);
      wait_done();

      // directed cases
      issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hDEAD_BEEF);
      issue(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 4'b0011, 2, 32'h0);
      issue(1'b1, 1'b1, 32'h0000_000C, 32'h5555_AAAA, 4'h6, 1, 32'hCAFE_0001);
      issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, -1, 32'h0);
      issue(1'b0, 1'b1, 32'h0000_0204, 32'h7777_0000, 4'h8, -1, 32'h0);
      issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, TMO - 1, 32'h1357_9BDF);

      // reset in the 2nd BUS cycle, then a stray ack in IDLE
      bus.read_req = 1'b1;
      bus.addr_in  = 32'h0000_0400;
      @(negedge clk);
      @(negedge clk);
      rst          = 1'b1;
      bus.read_req = 1'b0;
      @(negedge clk);
      check("midrst_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
      check("midrst_stb", {31'h0, bus.wb_stb_o}, 32'h0);
      check("midrst_busy", {31'h0, bus.busy}, 32'h0);
      check("midrst_done", {31'h0, bus.done}, 32'h0);
      check("midrst_rdata", bus.rdata_out, 32'h0);
      rst      = 1'b0;
      rd_model = 32'h0;
      stray_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
         check("stray_done", {31'h0, bus.done}, 32'h0);
         check("stray_rdata", bus.rdata_out, 32'h0);
      end
      stray_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 2);
         rd = (r != 1);
         wr = (r != 0);
         r  = $urandom_range(0, 9);
         if (r <= 5)      dly = r;
         else if (r == 6) dly = TMO - 1;
         else if (r == 7) dly = TMO;
         else             dly = -1;
         s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         issue(rd, wr, $urandom, $urandom, s, dly, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      check("scoreboard_empty", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
